// File: rtl/step_sequence_controller.sv
// Front-end controller for the two-switch sequence detector: debounces the step button,
// queues {sw1,sw2} symbols, feeds the detector, counts verdicts and enforces failure lockout.
module step_sequence_controller #(
  parameter int unsigned DEBOUNCE_DELAY = 500000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCK_CYCLES    = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       sw1,
  input  logic       sw2,
  output logic       sym_valid,
  output logic [1:0] sym_data,
  input  logic       sym_ready,
  input  logic       det_done,
  input  logic       det_match,
  output logic       det_clear,
  output logic       locked,
  output logic [7:0] outleds
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_DELAY + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_DELAY);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [1:0]       MAX_F     = 2'(MAX_FAILS);
  localparam logic [31:0]      LOCK_LAST = 32'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    CLEAR,
    LOCKOUT
  } state_t;

  state_t state, state_next;

  // Debounce
  logic            sync1, sync2;
  logic [DB_W-1:0] db_cnt;
  logic            pressed;
  logic            press_pulse;

  assign pressed     = !sync2;
  assign press_pulse = pressed && (db_cnt == DB_MAX - DB_ONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      db_cnt <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (!pressed)
        db_cnt <= '0;
      else if (db_cnt != DB_MAX)
        db_cnt <= db_cnt + DB_ONE;
    end
  end

  // Symbol FIFO
  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             push_req, push_ok, pop;
  logic             fifo_empty;

  assign fifo_empty = (count == '0);
  // CLEAR flushes the FIFO, so a press landing there is discarded rather than queued.
  assign push_req   = press_pulse && (state != LOCKOUT) && (state != CLEAR);
  assign pop        = sym_valid && sym_ready;
  assign push_ok    = push_req && ((count != DEPTH_C) || pop);
  assign sym_data   = sym_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {sw1, sw2};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (state == CLEAR) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)
        count <= count + CNT_ONE;
      else if (pop && !push_ok)
        count <= count - CNT_ONE;
      if (push_req && !push_ok)
        overflow <= 1'b1;
    end
  end

  // Verdict counters and lockout timer
  logic [3:0]  match_count, match_next;
  logic [1:0]  fail_count, fail_next;
  logic [31:0] lock_timer, timer_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      match_count <= '0;
      fail_count  <= '0;
      lock_timer  <= '0;
      outleds     <= '0;
    end else begin
      state       <= state_next;
      match_count <= match_next;
      fail_count  <= fail_next;
      lock_timer  <= timer_next;
      outleds     <= {match_count, (state == LOCKOUT), overflow, fail_count};
    end
  end

  always_comb begin
    state_next = state;
    match_next = match_count;
    fail_next  = fail_count;
    timer_next = '0;
    sym_valid  = 1'b0;
    det_clear  = 1'b0;
    locked     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty)
          state_next = FEED;
      end
      FEED: begin
        sym_valid = !fifo_empty;
        if (det_done) begin
          if (det_match) begin
            match_next = match_count + 4'd1;
            fail_next  = '0;
            state_next = CLEAR;
          end else if (fail_count + 2'd1 == MAX_F) begin
            fail_next  = MAX_F;
            state_next = LOCKOUT;
          end else begin
            fail_next  = fail_count + 2'd1;
            state_next = CLEAR;
          end
        end
      end
      CLEAR: begin
        det_clear  = 1'b1;
        state_next = IDLE;
      end
      LOCKOUT: begin
        locked    = 1'b1;
        det_clear = 1'b1;
        // Timer starts at 0 on entry, so LOCKOUT lasts exactly LOCK_CYCLES cycles.
        if (lock_timer == LOCK_LAST) begin
          fail_next  = '0;
          state_next = CLEAR;
        end else begin
          timer_next = lock_timer + 32'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_step_sequence_controller.sv
// Bench for step_sequence_controller: queue-based behavioural model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_step_sequence_controller;

  localparam int DD = 4;
  localparam int FD = 4;
  localparam int MF = 3;
  localparam int LC = 20;

  logic       clk = 1'b0;
  logic       reset, button, sw1, sw2, sym_ready, det_done, det_match;
  logic       sym_valid, det_clear, locked;
  logic [1:0] sym_data;
  logic [7:0] outleds;

  step_sequence_controller #(
    .DEBOUNCE_DELAY(DD),
    .FIFO_DEPTH    (FD),
    .MAX_FAILS     (MF),
    .LOCK_CYCLES   (LC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .button   (button),
    .sw1      (sw1),
    .sw2      (sw2),
    .sym_valid(sym_valid),
    .sym_data (sym_data),
    .sym_ready(sym_ready),
    .det_done (det_done),
    .det_match(det_match),
    .det_clear(det_clear),
    .locked   (locked),
    .outleds  (outleds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  typedef enum int {M_IDLE, M_FEED, M_CLEAR, M_LOCK} mode_t;
  mode_t      m_mode = M_IDLE;
  logic [1:0] m_q[$];
  int         m_match = 0, m_fail = 0, m_lock_t = 0, m_run = 0;
  bit         m_ovf = 0, m_b1 = 1, m_b2 = 1, started = 0;
  logic [7:0] m_leds = '0;

  task automatic model_step();
    bit pressed, pulse, pop;
    int sz;
    if (!reset) begin
      m_mode = M_IDLE; m_q.delete(); m_match = 0; m_fail = 0; m_lock_t = 0;
      m_run = 0; m_ovf = 0; m_b1 = 1; m_b2 = 1; m_leds = '0;
      return;
    end
    m_leds  = {4'(m_match % 16), (m_mode == M_LOCK), m_ovf, 2'(m_fail)};
    // A press is accepted on its DD-th consecutive low cycle after the 2-cycle synchroniser.
    pressed = !m_b2;
    pulse   = pressed && (m_run + 1 == DD);
    m_run   = pressed ? ((m_run < DD) ? m_run + 1 : m_run) : 0;
    m_b2    = m_b1;
    m_b1    = button;
    sz      = m_q.size();
    pop     = (m_mode == M_FEED) && (sz > 0) && sym_ready;
    case (m_mode)
      M_CLEAR: begin
        m_q.delete();
        m_ovf  = 0;
        m_mode = M_IDLE;
      end
      M_LOCK: begin
        if (m_lock_t == LC - 1) begin
          m_fail = 0;
          m_mode = M_CLEAR;
        end else begin
          m_lock_t++;
        end
      end
      default: begin
        if (pop) void'(m_q.pop_front());
        if (pulse) begin
          if (sz < FD || pop) m_q.push_back({sw1, sw2});
          else m_ovf = 1;
        end
        if (m_mode == M_IDLE) begin
          if (sz > 0) m_mode = M_FEED;
        end else if (det_done) begin
          if (det_match) begin
            m_match++; m_fail = 0; m_mode = M_CLEAR;
          end else if (m_fail + 1 == MF) begin
            m_fail = MF; m_lock_t = 0; m_mode = M_LOCK;
          end else begin
            m_fail++; m_mode = M_CLEAR;
          end
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    started = 1;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("sym_valid", 32'(sym_valid), 32'((m_mode == M_FEED) && (m_q.size() > 0)));
      if ((m_mode == M_FEED) && (m_q.size() > 0))
        chk("sym_data", 32'(sym_data), 32'(m_q[0]));
      chk("det_clear", 32'(det_clear), 32'((m_mode == M_CLEAR) || (m_mode == M_LOCK)));
      chk("locked", 32'(locked), 32'(m_mode == M_LOCK));
      chk("outleds", 32'(outleds), 32'(m_leds));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic press(input logic [1:0] sw, input int hold);
    {sw1, sw2} = sw;
    button = 1'b0;
    cyc(hold);
    button = 1'b1;
    cyc(4);
  endtask

  task automatic verdict(input logic m);
    det_done  = 1'b1;
    det_match = m;
    cyc(1);
    det_done  = 1'b0;
    det_match = 1'b0;
  endtask

  task automatic feed_verdict(input logic m);
    press(2'b11, 10);
    verdict(m);
    cyc(2);
  endtask

  initial begin
    int n;
    reset = 1'b0; button = 1'b1; sw1 = 1'b0; sw2 = 1'b0;
    sym_ready = 1'b0; det_done = 1'b0; det_match = 1'b0;
    cyc(3);
    chk("rst_outleds", 32'(outleds), 32'h00);
    chk("rst_valid", 32'(sym_valid), 0);
    chk("rst_clear", 32'(det_clear), 0);
    chk("rst_locked", 32'(locked), 0);
    reset = 1'b1;
    cyc(1);

    // Debounce: glitch, single hold, re-press
    button = 1'b0; cyc(3); button = 1'b1; cyc(8);
    chk("glitch_no_push", 32'(sym_valid), 0);
    press(2'b10, 10);
    chk("hold_valid", 32'(sym_valid), 1);
    chk("hold_data", 32'(sym_data), 32'h2);
    sym_ready = 1'b1; cyc(1); sym_ready = 1'b0; cyc(1);
    chk("hold_one_push", 32'(sym_valid), 0);
    press(2'b01, 10);
    chk("repress_data", 32'(sym_data), 32'h1);
    chk("repress_valid", 32'(sym_valid), 1);

    // Feed three symbols then a match
    do_reset();
    sym_ready = 1'b1;
    repeat (3) press(2'b11, 10);
    verdict(1'b1);
    chk("match_clear", 32'(det_clear), 1);
    cyc(1);
    chk("match_clear_1cyc", 32'(det_clear), 0);
    chk("match_leds", 32'(outleds), 32'h10);
    chk("match_empty", 32'(sym_valid), 0);

    // Backpressure and overflow
    do_reset();
    sym_ready = 1'b0;
    repeat (5) press(2'b01, 10);
    chk("ovf_leds", 32'(outleds), 32'h04);
    chk("ovf_hold_data", 32'(sym_data), 32'h1);
    sym_ready = 1'b1;
    cyc(4);
    chk("ovf_drained", 32'(sym_valid), 0);

    // Lockout after three failures, presses during lockout ignored
    do_reset();
    sym_ready = 1'b1;
    feed_verdict(1'b0);
    chk("fail1_leds", 32'(outleds), 32'h01);
    feed_verdict(1'b0);
    chk("fail2_leds", 32'(outleds), 32'h02);
    press(2'b11, 10);
    verdict(1'b0);
    n = 0;
    while (locked === 1'b1 && n < 100) begin
      n++;
      button = !(n >= 2 && n < 12);
      if (n == 5) chk("lock_leds", 32'(outleds), 32'h0B);
      cyc(1);
    end
    button = 1'b1;
    chk("lock_cycles", 32'(n), 32'(LC));
    chk("lock_then_clear", 32'(det_clear), 1);
    cyc(2);
    chk("unlock_leds", 32'(outleds), 32'h00);
    chk("unlock_valid", 32'(sym_valid), 0);

    // Match resets failures; det_done outside FEED ignored; match counter wrap
    do_reset();
    verdict(1'b1);
    cyc(2);
    chk("done_in_idle", 32'(outleds), 32'h00);
    feed_verdict(1'b0);
    feed_verdict(1'b0);
    feed_verdict(1'b1);
    chk("fail_reset_leds", 32'(outleds), 32'h10);
    repeat (14) feed_verdict(1'b1);
    chk("match15_leds", 32'(outleds), 32'hF0);
    feed_verdict(1'b1);
    chk("match_wrap_leds", 32'(outleds), 32'h00);

    // Reset during FEED with three queued symbols
    do_reset();
    sym_ready = 1'b1;
    feed_verdict(1'b1);
    sym_ready = 1'b0;
    repeat (3) press(2'b10, 10);
    chk("pre_rst_valid", 32'(sym_valid), 1);
    reset = 1'b0; cyc(1);
    chk("rst_feed_leds", 32'(outleds), 32'h00);
    chk("rst_feed_valid", 32'(sym_valid), 0);
    reset = 1'b1; cyc(3);
    chk("rst_feed_empty", 32'(sym_valid), 0);

    // Reset during LOCKOUT
    sym_ready = 1'b1;
    repeat (2) feed_verdict(1'b0);
    press(2'b11, 10);
    verdict(1'b0);
    cyc(5);
    chk("pre_rst_locked", 32'(locked), 1);
    reset = 1'b0; cyc(1);
    chk("rst_lock_locked", 32'(locked), 0);
    chk("rst_lock_clear", 32'(det_clear), 0);
    chk("rst_lock_leds", 32'(outleds), 32'h00);
    reset = 1'b1; cyc(3);
    chk("rst_lock_idle", 32'(det_clear), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
